fa_design: RTL and testbench

// - Registered full adder: adds operands a, b and carry-in c; produces sum and carry-out.
// - WIDTH=1 is the classic 1-bit full adder. WIDTH>1 is a ripple chain of 1-bit

---
 rtl/fa_design.sv | 63 ++++++
 tb/tb_fa_design.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fa_design.sv
// Registered ripple-carry full adder: {carry,sum} = a + b + c, one-cycle latency.
// Optional statistics counters are enabled by defining FA_STATS_EN.
module fa_design #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FA_STATS_EN
  ,
  output logic [15:0]      txn_count,
  output logic [15:0]      cout_count
`endif
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s_comb;

  // Ripple chain of 1-bit full-adder cells, carry-in enters at bit 0.
  always_comb begin
    k      = '0;
    s_comb = '0;
    k[0]   = c;
    for (int i = 0; i < WIDTH; i++) begin
      s_comb[i] = a[i] ^ b[i] ^ k[i];
      k[i+1]    = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Result registers only load on a valid operand, so idle inputs are ignored.
      if (in_valid) begin
        sum   <= s_comb;
        carry <= k[WIDTH];
      end
    end
  end

`ifdef FA_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count  <= 16'h0000;
      cout_count <= 16'h0000;
    end else if (in_valid) begin
      if (txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
      if (k[WIDTH] && (cout_count != 16'hFFFF)) cout_count <= cout_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fa_design.sv
// Self-checking bench for fa_design: WIDTH=1 and WIDTH=4 instances against an arithmetic model.
// Define FA_STATS_EN to also exercise the statistics counters.
module tb_fa_design;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       ov1, s1, k1;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       ov4, k4;
  logic [3:0] s4;
`ifdef FA_STATS_EN
  logic [15:0] txn1, cnt1, txn4, cnt4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fa_design #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .sum(s1), .carry(k1)
`ifdef FA_STATS_EN
    , .txn_count(txn1), .cout_count(cnt1)
`endif
  );

  fa_design #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .out_valid(ov4), .sum(s4), .carry(k4)
`ifdef FA_STATS_EN
    , .txn_count(txn4), .cout_count(cnt4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    v1 = 1'b0; v4 = 1'b0; rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({ov1, k1, s1} !== 3'b000) begin
      bad++; $display("FAIL reset_w1 got ov/carry/sum=%b required 000", {ov1, k1, s1});
    end
    total++;
    if ({ov4, k4, s4} !== 6'b000000) begin
      bad++; $display("FAIL reset_w4 got ov=%b carry=%b sum=%h required 0 0 0", ov4, k4, s4);
    end
  endtask

  task automatic test_exhaustive_w1();
    for (int i = 0; i < 8; i++) begin
      int exp;
      a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); c1 = 1'(i & 1); v1 = 1'b1;
      exp = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      step();
      total++;
      if ({ov1, k1, s1} !== {1'b1, 2'(exp)}) begin
        bad++;
        $display("FAIL exh_w1 abc=%0d got ov=%b carry=%b sum=%b required 1 %0d %0d",
                 i, ov1, k1, s1, exp / 2, exp % 2);
      end
    end
    v1 = 1'b0;
    step();
  endtask

  task automatic test_w4_vectors();
    logic [3:0] ta [4] = '{4'hF, 4'h5, 4'hF, 4'h0};
    logic [3:0] tb [4] = '{4'h1, 4'hA, 4'hF, 4'h0};
    logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      int exp;
      a4 = ta[i]; b4 = tb[i]; c4 = tc[i]; v4 = 1'b1;
      exp = int'(ta[i]) + int'(tb[i]) + int'(tc[i]);
      step();
      total++;
      if ({ov4, k4, s4} !== {1'b1, 5'(exp)}) begin
        bad++;
        $display("FAIL vec_w4 a=%h b=%h c=%b got ov=%b carry=%b sum=%h required 1 %0d %h",
                 ta[i], tb[i], tc[i], ov4, k4, s4, exp / 16, exp % 16);
      end
    end
    v4 = 1'b0;
    step();
  endtask

  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    step();
    total++;
    if ({ov1, k1, s1} !== 3'b101) begin
      bad++; $display("FAIL hold_setup got ov/carry/sum=%b required 101", {ov1, k1, s1});
    end
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({ov1, k1, s1} !== 3'b001) begin
        bad++; $display("FAIL hold_cyc%0d got ov/carry/sum=%b required 001", i, {ov1, k1, s1});
      end
    end
  endtask

  task automatic test_reset_collision();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; v1 = 1'b0;
    total++;
    if ({ov1, k1, s1} !== 3'b000) begin
      bad++; $display("FAIL rst_collide got ov/carry/sum=%b required 000", {ov1, k1, s1});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({ov1, k1, s1} !== 3'b000) begin
        bad++; $display("FAIL rst_late%0d got ov/carry/sum=%b required 000", i, {ov1, k1, s1});
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) begin
      int exp;
      a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); c4 = 1'($urandom_range(0, 1));
      v4 = 1'b1;
      exp = int'(a4) + int'(b4) + int'(c4);
      step();
      total++;
      if (ov4 !== 1'b1 || {k4, s4} !== 5'(exp)) begin
        bad++;
        $display("FAIL stream%0d got ov=%b {carry,sum}=%0d required 1 %0d", i, ov4, {k4, s4}, exp);
      end
    end
    v4 = 1'b0;
    step();
    total++;
    if (ov4 !== 1'b0) begin
      bad++; $display("FAIL stream_end got ov=%b required 0", ov4);
    end
  endtask

`ifdef FA_STATS_EN
  task automatic test_stats();
    int n_txn = 0;
    int n_cout = 0;
    rst = 1'b1; v4 = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) begin
        a4 = 4'($urandom_range(8, 15)); b4 = 4'($urandom_range(8, 15));
      end else begin
        a4 = 4'($urandom_range(0, 7)); b4 = 4'($urandom_range(0, 7));
      end
      c4 = 1'($urandom_range(0, 1)); v4 = 1'b1;
      n_txn++;
      if (int'(a4) + int'(b4) + int'(c4) > 15) n_cout++;
      step();
      total++;
      if (txn4 !== 16'(n_txn) || cnt4 !== 16'(n_cout)) begin
        bad++;
        $display("FAIL stats_op%0d got txn=%0d cout=%0d required %0d %0d", i, txn4, cnt4, n_txn, n_cout);
      end
    end
    v4 = 1'b0;
    step();
    total++;
    if (txn4 !== 16'd10 || cnt4 !== 16'd4) begin
      bad++; $display("FAIL stats_final got txn=%0d cout=%0d required 10 4", txn4, cnt4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (txn4 !== 16'd0 || cnt4 !== 16'd0) begin
      bad++; $display("FAIL stats_clear got txn=%0d cout=%0d required 0 0", txn4, cnt4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_w4_vectors();
    test_hold();
    test_reset_collision();
    test_back_to_back();
`ifdef FA_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
